// File: rtl/tl_main_pkg.sv
// Address map and connectivity of the main host port.
package tl_main_pkg;

   localparam int unsigned NumDevHost         = 4;
   localparam int unsigned MaxOutstandingHost = 2;

   // Index 0 is the rightmost element of each concatenation.
   localparam logic [NumDevHost-1:0][31:0] AddrSpaceHost = {
      32'h4000_1000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000
   };
   localparam logic [NumDevHost-1:0][31:0] AddrMaskHost = {
      32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_FFFF, 32'h000F_FFFF
   };
   localparam logic [NumDevHost-1:0] ConnMaskHost = 4'b1011;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcodes shared by the interconnect.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_err_resp.sv
// Error responder: latches an unmapped request and returns one error
// response to the host, holding it until the host takes it.
module tlul_err_resp
   import tlul_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       accept_i,
   input  tl_a_op_e   a_opcode_i,
   input  logic [7:0] a_source_i,
   input  logic [1:0] a_size_i,
   input  logic       d_ready_i,
   output logic       busy_o,
   output tl_d2h_t    rsp_o
);

   typedef enum logic {StErrIdle, StErrRsp} err_state_e;

   err_state_e state_q, state_d;
   tl_a_op_e   opcode_q;
   logic [7:0] source_q;
   logic [1:0] size_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StErrIdle;
         opcode_q <= PutFullData;
         source_q <= '0;
         size_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept_i) begin
            opcode_q <= a_opcode_i;
            source_q <= a_source_i;
            size_q   <= a_size_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StErrIdle: if (accept_i)  state_d = StErrRsp;
         StErrRsp:  if (d_ready_i) state_d = StErrIdle;
         default:                  state_d = StErrIdle;
      endcase
   end

   assign busy_o = (state_q == StErrRsp);

   always_comb begin
      rsp_o          = '0;
      rsp_o.d_valid  = busy_o;
      rsp_o.d_opcode = (opcode_q == Get) ? AccessAckData : AccessAck;
      rsp_o.d_source = source_q;
      rsp_o.d_size   = size_q;
      rsp_o.d_data   = 32'hFFFF_FFFF;
      rsp_o.d_error  = 1'b1;
   end

endmodule

// File: rtl/tlul_addr_demux.sv
// TL-UL 1:N address demultiplexer. Requests to different devices are never
// reordered: a new target is only taken once all earlier responses returned.
module tlul_addr_demux
   import tlul_pkg::*;
#(
   parameter int unsigned        N              = 4,
   parameter int unsigned        MaxOutstanding = 4,
   parameter logic [N-1:0][31:0] AddrSpace      = '0,
   parameter logic [N-1:0][31:0] AddrMask       = '0,
   parameter logic [N-1:0]       ConnMask       = '1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  tl_h2d_t                               tl_h_i,
   output tl_d2h_t                               tl_h_o,
   output tl_h2d_t                               tl_d_o [N],
   input  tl_d2h_t                               tl_d_i [N],
   output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
   output logic                                  err_o
);

   localparam int unsigned     SelW   = $clog2(N + 1);
   localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
   localparam logic [SelW-1:0] SelErr = SelW'(N);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   typedef enum logic {StIdle, StActive} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [SelW-1:0] tgt_q, tgt_d;
   logic [SelW-1:0] sel;
   logic            sel_found;
   logic            sel_a_ready;
   tl_d2h_t         tgt_rsp;
   logic            err_busy;
   tl_d2h_t         err_rsp;
   logic            in_idle, sel_dev, can_fwd, err_acc, a_hs, d_hs;

   // Lowest matching, connected device wins.
   always_comb begin
      sel       = SelErr;
      sel_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!sel_found && ConnMask[i] &&
             ((tl_h_i.a_address & ~AddrMask[i]) == AddrSpace[i])) begin
            sel       = SelW'(i);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a_ready = 1'b0;
      tgt_rsp     = '0;
      for (int j = 0; j < N; j++) begin
         if (sel == SelW'(j))   sel_a_ready = tl_d_i[j].a_ready;
         if (tgt_q == SelW'(j)) tgt_rsp     = tl_d_i[j];
      end
   end

   // rst_ni gates the combinational paths so nothing leaks out during reset.
   assign in_idle = rst_ni && (state_q == StIdle) && !err_busy;
   assign sel_dev = (sel != SelErr);
   assign can_fwd = sel_dev && (in_idle || (rst_ni && (state_q == StActive) &&
                                            (sel == tgt_q) && (cnt_q < CntMax)));
   assign err_acc = in_idle && !sel_dev && tl_h_i.a_valid;
   assign a_hs    = can_fwd && tl_h_i.a_valid && sel_a_ready;
   assign d_hs    = (state_q == StActive) && tgt_rsp.d_valid && tl_h_i.d_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      if (a_hs)    tgt_d = sel;
      if (err_acc) tgt_d = SelErr;
      if (a_hs && !d_hs)      cnt_d = cnt_q + CntW'(1);
      else if (!a_hs && d_hs) cnt_d = cnt_q - CntW'(1);
      unique case (state_q)
         StIdle:   if (a_hs)           state_d = StActive;
         StActive: if (cnt_d == '0)    state_d = StIdle;
         default:                      state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      for (int j = 0; j < N; j++) begin
         tl_d_o[j]         = tl_h_i;
         tl_d_o[j].a_valid = can_fwd && tl_h_i.a_valid && (sel == SelW'(j));
         tl_d_o[j].d_ready = rst_ni && (state_q == StActive) && (tgt_q == SelW'(j)) &&
                             tl_h_i.d_ready;
      end
      tl_h_o = '0;
      if (state_q == StActive) tl_h_o = tgt_rsp;
      else if (err_busy)       tl_h_o = err_rsp;
      tl_h_o.a_ready = can_fwd ? sel_a_ready : (in_idle && !sel_dev);
   end

   assign outstanding_o = cnt_q;
   assign err_o         = err_acc;

   tlul_err_resp u_err_resp (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .accept_i   (err_acc),
      .a_opcode_i (tl_h_i.a_opcode),
      .a_source_i (tl_h_i.a_source),
      .a_size_i   (tl_h_i.a_size),
      .d_ready_i  (tl_h_i.d_ready),
      .busy_o     (err_busy),
      .rsp_o      (err_rsp)
   );

endmodule
